// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp
//   SPI responder standing in for an 8-channel, 12-bit A2D converter.
//   Each 16-bit command frame names a channel in bits [13:11]. The reply
//   shifted out on MISO during a frame is the value of the channel named
//   by the previous complete frame, as {4'h0, value[11:0]}, MSB first.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   SS_n       slave select from master, active low (asynchronous to clk)
//   SCLK       serial clock from master, idles high (asynchronous to clk)
//   MOSI       master data, captured on SCLK rise
//   chan_vals  channel n value at [12n+11:12n]
//   MISO       responder data, advances after each SCLK fall
//   cmd_vld    one-clk pulse when a complete 16-bit frame ends
//   cmd_chnl   channel decoded from the last complete frame
//   frm_err    one-clk pulse when SS_n rises before 16 SCLK rises
module a2d_spi_resp #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic [95:0] chan_vals,
  output logic        MISO,
  output logic        cmd_vld,
  output logic [2:0]  cmd_chnl,
  output logic        frm_err
);

  typedef enum logic [1:0] {IDLE, PORCH, SHIFT} state_t;

  // Pin bundle ordering: {SS_n, SCLK, MOSI}. Idle levels: SS_n/SCLK high.
  localparam logic [2:0] PIN_RST = 3'b110;
  // Clocks until the edge flop reflects the real pin level after reset.
  localparam logic [2:0] HOLD    = 3'(SYNC_STAGES + 1);

  logic [2:0]  sync_q [SYNC_STAGES];
  logic [2:0]  pin_s;
  logic [2:0]  d1_q;
  logic        ss_fall_q, ss_rise_q, sclk_fall_q, sclk_rise_q, mosi_q;
  logic [2:0]  hold_q;
  logic        armed_q;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] tx_q, tx_d;
  logic [2:0]  sel_q, sel_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;

  logic [11:0] chan_arr [8];

  // Input synchronizers, one stage per generate iteration.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q[gi] <= PIN_RST;
      end else if (gi == 0) begin
        sync_q[gi] <= {SS_n, SCLK, MOSI};
      end else begin
        sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi - 1];
      end
    end
  end

  assign pin_s = sync_q[SYNC_STAGES-1];

  for (genvar gi = 0; gi < 8; gi++) begin : g_chan
    assign chan_arr[gi] = chan_vals[12*gi +: 12];
  end

  // Edge flop plus registered edge pulses. MOSI is delayed alongside so
  // the captured bit lines up with the SCLK rise pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q        <= PIN_RST;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      sclk_fall_q <= 1'b0;
      sclk_rise_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      d1_q        <= pin_s;
      ss_fall_q   <=  d1_q[2] & ~pin_s[2];
      ss_rise_q   <= ~d1_q[2] &  pin_s[2];
      sclk_fall_q <=  d1_q[1] & ~pin_s[1];
      sclk_rise_q <= ~d1_q[1] &  pin_s[1];
      mosi_q      <= pin_s[0];
    end
  end

  // After a reset the synchronizers start at idle levels while the pin may
  // still be low mid-frame; that apparent SS_n fall must not open a frame.
  // Frames are accepted only once SS_n has really been seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      if (hold_q != HOLD) hold_q <= hold_q + 3'd1;
      if (hold_q == HOLD && d1_q[2]) armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    sel_d     = sel_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    if (state_q != IDLE && ss_rise_q) begin
      if (bit_cnt_q == 5'd16) begin
        vld_d = 1'b1;
        sel_d = rx_q[13:11];
      end else begin
        err_d = 1'b1;
      end
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall_q && armed_q) begin
            tx_d      = {4'h0, chan_arr[sel_q]};
            bit_cnt_d = '0;
            state_d   = PORCH;
          end
        end
        PORCH, SHIFT: begin
          if (sclk_rise_q) begin
            rx_d = {rx_q[14:0], mosi_q};
            // Saturate so an over-long frame still counts as complete.
            if (bit_cnt_q != 5'd16) bit_cnt_d = bit_cnt_q + 5'd1;
          end
          if (sclk_fall_q) begin
            // The first fall after SS_n only ends the porch; MISO already
            // holds bit 15 at that point.
            if (state_q == PORCH) state_d = SHIFT;
            else                  tx_d    = {tx_q[14:0], 1'b0};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      sel_q     <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      sel_q     <= sel_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign MISO     = tx_q[15];
  assign cmd_vld  = vld_q;
  assign frm_err  = err_q;
  assign cmd_chnl = sel_q;

endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

Synthesizable SPI responder that models the 8-channel, 12-bit A2D converter on the far end of the Segway A2D SPI link. It decodes 16-bit command frames from the SPI master (channel in bits [13:11]) and returns the conversion result of the channel named in the previous complete frame, MSB first on MISO. It sits in the FPGA test harness and board-level sim, standing in for the physical converter, with channel values supplied by the surrounding bench or plant model.

## Interface
- SYNC_STAGES, 2, flops in each input synchronizer (legal 2..3)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active high
- SS_n  in  1  slave select from master, active low, asynchronous to clk
- SCLK  in  1  serial clock from master, idles high, asynchronous to clk
- MOSI  in  1  master-out data, sampled on SCLK rise
- chan_vals  in  96  channel n value at [12n+11:12n], n=0..7
- MISO  out  1  responder data, changes after SCLK fall
- cmd_vld  out  1  one-clk pulse: complete 16-bit frame received
- cmd_chnl  out  3  channel decoded from last complete frame
- frm_err  out  1  one-clk pulse: SS_n deasserted before 16 SCLK rises

## Operation
- Reset is synchronous and active high, on the single clock clk. On rst: SS_n/SCLK sync flops to 1, MOSI sync to 0, state IDLE, bit_cnt 0, rx_shift 0, tx_shift 0, sel 0, cmd_chnl 0, cmd_vld 0, frm_err 0, MISO 0.
- SS_n, SCLK, MOSI pass through SYNC_STAGES-flop synchronizers plus one edge-detect flop; all logic uses synchronized signals and detected edges only.
- FSM states: IDLE, PORCH, SHIFT.
- IDLE: on SS_n fall, load tx_shift = {4'h0, chan_vals[12*sel +: 12]}, clear bit_cnt, go PORCH. MISO = tx_shift[15] from the next clk.
- PORCH: first SCLK fall after SS_n fall does not shift; go SHIFT.
- SHIFT: each SCLK rise: rx_shift = {rx_shift[14:0], MOSI_sync}, bit_cnt+1. Each SCLK fall: tx_shift = {tx_shift[14:0], 1'b0}.
- A SCLK rise seen in PORCH is also sampled (master may skip the porch fall only if SCLK is already low; treat it identically).
- Any state, SS_n rise: if bit_cnt == 16, pulse cmd_vld, cmd_chnl = sel = rx_shift[13:11]; else pulse frm_err, sel and cmd_chnl unchanged. Go IDLE either way. No pulse on an SS_n rise while in IDLE.
- Bits [15:14] and [10:0] of the command are ignored. More than 16 rises: bit_cnt saturates at 16, rx_shift keeps shifting (last 16 bits count).
- chan_vals is sampled only at the SS_n fall. Later changes do not affect the frame in flight.
- Response word upper nibble is always 0.
- rst in mid-frame: return to IDLE immediately and keep the reset values. The remainder of the frame is ignored until the next SS_n fall.

## Timing
- Pin-edge to internal detect latency: SYNC_STAGES+1 clk. MISO updates 1 clk after detect.
- Required master timing: SCLK high and low phases ≥ SYNC_STAGES+3 clk each. SS_n fall to first SCLK fall ≥ SYNC_STAGES+3 clk. Satisfied by the clk/32 SCLK master.
- MISO bit k (k=15..0) is valid from the detect of the fall preceding its rise through the following fall.
- cmd_vld/frm_err are asserted exactly 1 clk, SYNC_STAGES+2 clk after the SS_n pin rise.
- Back-to-back frames: SS_n high ≥ 2 clk after sync suffices. sel updated by frame N applies to frame N+1.

## Test plan
- Reset, ch0=0xABC: frame cmd 0x0000 -> MISO shifts 0x0ABC, cmd_vld pulse, cmd_chnl=0.
- ch4=0x123, frames 0x2000 then 0x2000 -> responses 0x0ABC then 0x0123, cmd_chnl=4 after each.
- Full round robin with the A2D master (ch 0,4,5,6, two frames each) -> master lft_ld/rght_ld/steer_pot/batt equal ch0/4/5/6 values.
- SS_n raised after 9 rises of cmd 0x2800 -> frm_err pulse, no cmd_vld, next response still from previous sel.
- Change ch0 from 0x111 to 0x222 mid-frame -> response 0x0111. Next ch0 frame returns 0x0222.
- Assert rst after 5 rises -> MISO=0, cmd_chnl=0, no pulses. The next full frame behaves as after reset.
